// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - debounces a 16-key active-low image and serializes press/release events
module key_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int CNT_W           = 18
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [15:0] key_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_code,
    output logic        evt_press,
    output logic [15:0] key_stable,
    output logic        held_valid,
    output logic [3:0]  held_code
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    logic [15:0]      s1_q, s1_d;
    logic [15:0]      s2_q, s2_d;
    logic [15:0]      cand_q, cand_d;
    logic [15:0]      stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      pend_p_q, pend_p_d;
    logic [15:0]      pend_r_q, pend_r_d;
    state_t           state_q, state_d;
    logic             evt_valid_q, evt_valid_d;
    logic [3:0]       evt_code_q, evt_code_d;
    logic             evt_press_q, evt_press_d;
    logic             held_valid_q, held_valid_d;
    logic [3:0]       held_code_q, held_code_d;

    logic             stable_upd;
    logic [15:0]      press_edges;
    logic [15:0]      rel_edges;
    logic [15:0]      clr_p;
    logic [15:0]      clr_r;
    logic [15:0]      pend_any;
    logic [3:0]       sel_idx;

    // Debounce the whole image as one vector; a change restarts the count.
    always_comb begin
        s1_d       = key_in;
        s2_d       = s1_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        stable_upd = 1'b0;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        if ((cnt_q == CNT_MAX) && (cand_q != stable_q)) begin
            stable_d   = cand_q;
            stable_upd = 1'b1;
        end
    end

    always_comb begin
        press_edges = '0;
        rel_edges   = '0;
        if (stable_upd) begin
            press_edges = ~cand_q & stable_q;
            rel_edges   = cand_q & ~stable_q;
        end
        // New edges are OR-ed in after the clear so they survive a same-cycle clear.
        pend_p_d = (pend_p_q & ~clr_p) | press_edges;
        pend_r_d = (pend_r_q & ~clr_r) | rel_edges;
    end

    always_comb begin
        pend_any = pend_p_q | pend_r_q;
        sel_idx  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend_any[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    // Press is preferred over release for the same key so press always goes first.
    always_comb begin
        state_d     = state_q;
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_press_d = evt_press_q;
        clr_p       = '0;
        clr_r       = '0;
        case (state_q)
            IDLE: begin
                if (pend_any != '0) begin
                    evt_code_d  = sel_idx;
                    evt_valid_d = 1'b1;
                    state_d     = PRESENT;
                    if (pend_p_q[sel_idx]) begin
                        evt_press_d = 1'b1;
                        clr_p       = 16'h0001 << sel_idx;
                    end else begin
                        evt_press_d = 1'b0;
                        clr_r       = 16'h0001 << sel_idx;
                    end
                end
            end
            PRESENT: begin
                if (evt_valid_q && evt_ready) begin
                    evt_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        held_valid_d = |(~stable_q);
        held_code_d  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!stable_q[i]) begin
                held_code_d = 4'(i);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_q         <= 16'hffff;
            s2_q         <= 16'hffff;
            cand_q       <= 16'hffff;
            stable_q     <= 16'hffff;
            cnt_q        <= '0;
            pend_p_q     <= '0;
            pend_r_q     <= '0;
            state_q      <= IDLE;
            evt_valid_q  <= 1'b0;
            evt_code_q   <= 4'd0;
            evt_press_q  <= 1'b0;
            held_valid_q <= 1'b0;
            held_code_q  <= 4'd0;
        end else begin
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            cand_q       <= cand_d;
            stable_q     <= stable_d;
            cnt_q        <= cnt_d;
            pend_p_q     <= pend_p_d;
            pend_r_q     <= pend_r_d;
            state_q      <= state_d;
            evt_valid_q  <= evt_valid_d;
            evt_code_q   <= evt_code_d;
            evt_press_q  <= evt_press_d;
            held_valid_q <= held_valid_d;
            held_code_q  <= held_code_d;
        end
    end

    assign key_stable = ~stable_q;
    assign evt_valid  = evt_valid_q;
    assign evt_code   = evt_code_q;
    assign evt_press  = evt_press_q;
    assign held_valid = held_valid_q;
    assign held_code  = held_code_q;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - self-checking bench for key_event_encoder with a reference event model
module tb_key_event_encoder;

    localparam int D = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [15:0] key_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_code;
    logic        evt_press;
    logic [15:0] key_stable;
    logic        held_valid;
    logic [3:0]  held_code;

    int total = 0;
    int bad   = 0;

    logic [4:0] evq[$];

    key_event_encoder #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(18)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .key_in(key_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_code(evt_code),
        .evt_press(evt_press),
        .key_stable(key_stable),
        .held_valid(held_valid),
        .held_code(held_code)
    );

    always #5 clk_in = ~clk_in;

    // Handshakes are observed half a cycle before the edge that completes them.
    always @(negedge clk_in) begin
        if (!rst_in && evt_valid && evt_ready) begin
            evq.push_back({evt_code, evt_press});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic wait_q(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (evq.size() >= n) break;
            tick(1);
        end
        ok = (evq.size() >= n);
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (evt_valid) break;
            tick(1);
        end
        ok = evt_valid;
    endtask

    task automatic test_reset();
        bit         ok;
        logic [4:0] e;
        evq.delete();
        rst_in    = 1'b1;
        key_in    = 16'hfffe;
        evt_ready = 1'b1;
        tick(3);
        rst_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            total++;
            if ({key_stable, evt_valid, evt_code, evt_press, held_valid, held_code} !== 27'd0) begin
                bad++;
                $display("FAIL reset_quiet cycle %0d: stable=%h v=%b code=%h p=%b hv=%b hc=%h want all 0",
                         i, key_stable, evt_valid, evt_code, evt_press, held_valid, held_code);
            end
        end
        wait_q(1, 30, ok);
        total++;
        e = ok ? evq.pop_front() : 5'h1f;
        if (!ok || e !== {4'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_press0: got %h want %h (ok=%b)", e, {4'd0, 1'b1}, ok);
        end
        tick(2);
        total++;
        if ({key_stable, held_valid, held_code} !== {16'h0001, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL reset_held0: stable=%h hv=%b hc=%h want 0001 1 0", key_stable, held_valid, held_code);
        end
        key_in = 16'hffff;
        wait_q(1, 30, ok);
        total++;
        e = ok ? evq.pop_front() : 5'h1f;
        if (!ok || e !== {4'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_release0: got %h want %h (ok=%b)", e, {4'd0, 1'b0}, ok);
        end
        tick(4);
    endtask

    task automatic test_single();
        bit         ok;
        logic [4:0] e;
        evq.delete();
        evt_ready = 1'b1;
        key_in    = 16'hfffb;
        tick(D + 2);
        total++;
        if (key_stable !== 16'h0000) begin
            bad++;
            $display("FAIL single_early: stable=%h want 0000", key_stable);
        end
        tick(1);
        total++;
        if (key_stable !== 16'h0004) begin
            bad++;
            $display("FAIL single_latency: stable=%h want 0004", key_stable);
        end
        tick(1);
        total++;
        if ({held_valid, held_code} !== {1'b1, 4'd2}) begin
            bad++;
            $display("FAIL single_held: hv=%b hc=%h want 1 2", held_valid, held_code);
        end
        wait_q(1, 10, ok);
        tick(20);
        total++;
        if (evq.size() != 1) begin
            bad++;
            $display("FAIL single_count: events=%0d want 1", evq.size());
        end
        total++;
        e = (evq.size() > 0) ? evq.pop_front() : 5'h1f;
        if (e !== {4'd2, 1'b1}) begin
            bad++;
            $display("FAIL single_event: got %h want %h", e, {4'd2, 1'b1});
        end
        evq.delete();
        key_in = 16'hffff;
        wait_q(1, 30, ok);
        total++;
        e = ok ? evq.pop_front() : 5'h1f;
        if (!ok || e !== {4'd2, 1'b0}) begin
            bad++;
            $display("FAIL single_release: got %h want %h (ok=%b)", e, {4'd2, 1'b0}, ok);
        end
        tick(4);
    endtask

    task automatic test_bounce();
        bit glitch = 1'b0;
        evq.delete();
        evt_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            key_in = (((i / 3) % 2) == 0) ? 16'hfffe : 16'hffff;
            tick(1);
            if (key_stable !== 16'h0000) glitch = 1'b1;
        end
        key_in = 16'hffff;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (key_stable !== 16'h0000) glitch = 1'b1;
        end
        total++;
        if (glitch) begin
            bad++;
            $display("FAIL bounce_stable: key_stable left 0000 during bounce");
        end
        total++;
        if (evq.size() != 0) begin
            bad++;
            $display("FAIL bounce_events: events=%0d want 0", evq.size());
        end
    endtask

    task automatic test_two_keys();
        bit         ok;
        bit         held = 1'b1;
        logic [4:0] e;
        evq.delete();
        evt_ready = 1'b0;
        key_in    = ~16'h0022;
        wait_valid(D + 10, ok);
        for (int i = 0; i < 20; i++) begin
            if (!(evt_valid === 1'b1 && evt_code === 4'd1 && evt_press === 1'b1)) held = 1'b0;
            tick(1);
        end
        total++;
        if (!ok || !held) begin
            bad++;
            $display("FAIL two_hold: v=%b code=%h p=%b want 1 1 1 steady (ok=%b)", evt_valid, evt_code, evt_press, ok);
        end
        evt_ready = 1'b1;
        wait_q(2, 20, ok);
        total++;
        e = (evq.size() > 0) ? evq.pop_front() : 5'h1f;
        if (e !== {4'd1, 1'b1}) begin
            bad++;
            $display("FAIL two_first: got %h want %h", e, {4'd1, 1'b1});
        end
        total++;
        e = (evq.size() > 0) ? evq.pop_front() : 5'h1f;
        if (e !== {4'd5, 1'b1}) begin
            bad++;
            $display("FAIL two_second: got %h want %h", e, {4'd5, 1'b1});
        end
        key_in = 16'hffff;
        wait_q(2, 40, ok);
        total++;
        if (!ok || evq[0] !== {4'd1, 1'b0} || evq[1] !== {4'd5, 1'b0}) begin
            bad++;
            $display("FAIL two_release: events=%0d want 1r,5r", evq.size());
        end
        evq.delete();
        tick(4);
    endtask

    task automatic test_press_release_stalled();
        bit         ok;
        logic [4:0] e;
        evq.delete();
        evt_ready = 1'b0;
        key_in    = 16'hff7f;
        tick(D + 6);
        key_in = 16'hffff;
        tick(D + 6);
        total++;
        if ({key_stable, evt_valid, evt_code, evt_press} !== {16'h0000, 1'b1, 4'd7, 1'b1}) begin
            bad++;
            $display("FAIL stall_state: stable=%h v=%b code=%h p=%b want 0000 1 7 1",
                     key_stable, evt_valid, evt_code, evt_press);
        end
        evt_ready = 1'b1;
        wait_q(2, 20, ok);
        tick(10);
        total++;
        e = (evq.size() > 0) ? evq.pop_front() : 5'h1f;
        if (e !== {4'd7, 1'b1}) begin
            bad++;
            $display("FAIL stall_press7: got %h want %h", e, {4'd7, 1'b1});
        end
        total++;
        e = (evq.size() > 0) ? evq.pop_front() : 5'h1f;
        if (e !== {4'd7, 1'b0}) begin
            bad++;
            $display("FAIL stall_release7: got %h want %h", e, {4'd7, 1'b0});
        end
        total++;
        if (evq.size() != 0 || evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL stall_drained: extra=%0d v=%b want 0 0", evq.size(), evt_valid);
        end
    endtask

    task automatic test_reset_mid_event();
        bit ok;
        evq.delete();
        evt_ready = 1'b0;
        key_in    = 16'hfff6;
        wait_valid(D + 10, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL midrst_valid: v=%b want 1", evt_valid);
        end
        rst_in = 1'b1;
        key_in = 16'hffff;
        tick(1);
        total++;
        if ({evt_valid, key_stable, held_valid} !== 18'd0) begin
            bad++;
            $display("FAIL midrst_clear: v=%b stable=%h hv=%b want 0 0000 0", evt_valid, key_stable, held_valid);
        end
        tick(1);
        rst_in    = 1'b0;
        evt_ready = 1'b1;
        tick(D + 20);
        total++;
        if (evq.size() != 0 || evt_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_stale: events=%0d v=%b want 0 0", evq.size(), evt_valid);
        end
    endtask

    task automatic test_random();
        logic [15:0] cur = 16'h0000;
        logic [15:0] nxt;
        logic [4:0]  exp_q[$];
        logic [4:0]  e;
        int          k;
        for (int step = 0; step < 16; step++) begin
            nxt = ((step % 5) == 4) ? 16'h0000 : 16'($urandom);
            exp_q.delete();
            for (int i = 0; i < 16; i++) begin
                if (nxt[i] != cur[i]) exp_q.push_back({4'(i), nxt[i]});
            end
            evq.delete();
            key_in = ~nxt;
            for (int c = 0; c < 600 && evq.size() < exp_q.size(); c++) begin
                evt_ready = 1'($urandom_range(0, 1));
                tick(1);
            end
            evt_ready = 1'b1;
            tick(D + 10);
            total++;
            if (evq.size() != exp_q.size()) begin
                bad++;
                $display("FAIL rand_count step %0d: events=%0d want %0d", step, evq.size(), exp_q.size());
            end
            while (exp_q.size() > 0 && evq.size() > 0) begin
                e = evq.pop_front();
                total++;
                if (e !== exp_q[0]) begin
                    bad++;
                    $display("FAIL rand_event step %0d: got %h want %h", step, e, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            k = 0;
            while (k < 16 && !nxt[k]) k++;
            total++;
            if ({key_stable, held_valid, held_code} !== {nxt, (nxt != 16'h0), (nxt == 16'h0) ? 4'd0 : 4'(k)}) begin
                bad++;
                $display("FAIL rand_image step %0d: stable=%h hv=%b hc=%h want %h", step, key_stable,
                         held_valid, held_code, nxt);
            end
            cur = nxt;
        end
        key_in = 16'hffff;
        tick(D + 60);
        evq.delete();
    endtask

    initial begin
        rst_in    = 1'b1;
        key_in    = 16'hffff;
        evt_ready = 1'b0;
        test_reset();
        test_single();
        test_bounce();
        test_two_keys();
        test_press_release_stalled();
        test_reset_mid_event();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
